// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It synchronises the RxD pin, samples each bit at
// its midpoint, assembles bytes LSB first, and presents each byte on a
// valid/ready stream. Stop-bit errors and dropped bytes are reported as
// one-cycle pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic             rx_meta_reg;
    logic             rx_s_reg;
    logic [2:0]       state_reg,   state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;
    logic [7:0]       bit_load;

    logic bit_tick;
    logic half_tick;
    logic data_sample;
    logic stop_sample;
    logic deliver;
    logic stop_bad;

    assign bit_tick    = (bit_cnt_reg == CNT_LAST);
    assign half_tick   = (bit_cnt_reg == HALF_LAST);
    assign data_sample = (state_reg == ST_DATA) && bit_tick;
    assign stop_sample = (state_reg == ST_STOP) && bit_tick;
    assign deliver     = stop_sample && rx_s_reg;
    assign stop_bad    = stop_sample && !rx_s_reg;

    // Two-flop synchroniser; idle level is high so both flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Per-bit load enables: the bit selected by the index captures at mid-bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_load
            assign bit_load[gi] = data_sample && (bit_idx_reg == 3'(gi));
        end
    endgenerate

    // Shift register next value: only the addressed bit changes.
    always_comb begin
        shift_next = shift_reg;
        for (int i = 0; i < 8; i++) begin
            if (bit_load[i]) begin
                shift_next[i] = rx_s_reg;
            end
        end
    end

    // Frame sequencing: start qualification, mid-bit data sampling, stop check.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                bit_cnt_next = '0;
                if (!rx_s_reg) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_next   = rx_s_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    bit_cnt_next = '0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    bit_cnt_next = '0;
                    state_next   = rx_s_reg ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must return high before re-arming.
                bit_cnt_next = '0;
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Output holding register and handshake; a byte arriving into a full,
    // unaccepted holding register is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!m_valid || m_ready) begin
                    m_data  <= shift_reg;
                    m_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
